// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO: owns the binary/Gray write
// pointers and derives full, almost-full, fill level and overflow in clk.
module fifo_wr_ctrl #(
  parameter int WIDTH        = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             ovf_clr,
  input  logic [WIDTH:0]   rptr_gray_sync,
  output logic             mem_we,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH:0]   wptr_gray,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH:0]   wr_level,
  output logic             overflow
);

  localparam logic [WIDTH:0] THRESH = AFULL_THRESH[WIDTH:0];

  logic             accept;
  logic [WIDTH:0]   wbin;
  logic [WIDTH:0]   wbin_next;
  logic [WIDTH:0]   wgray_next;
  logic [WIDTH:0]   rbin;
  logic [WIDTH:0]   level_next;
  logic             full_next;
  logic             almost_full_next;

  assign accept = wr_en & ~full & ~rst;
  assign mem_we = accept;
  assign waddr  = wbin[WIDTH-1:0];

  // Next-state pointer and flag arithmetic; flags are computed from the
  // post-write pointer so they reflect an accepted write with no extra latency.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      rbin[i] = ^(rptr_gray_sync >> i);
    end
    wbin_next        = wbin + {{WIDTH{1'b0}}, accept};
    wgray_next       = wbin_next ^ (wbin_next >> 1);
    full_next        = (wgray_next == {~rptr_gray_sync[WIDTH:WIDTH-1],
                                       rptr_gray_sync[WIDTH-2:0]});
    level_next       = wbin_next - rbin;
    almost_full_next = (level_next >= THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      wr_level    <= level_next;
      // A rejected write sets the sticky flag and beats a simultaneous clear.
      if (wr_en & full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: a count-based model of writes and reads
// predicts each cycle's outputs; a monitor process compares them to the DUT.
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       ovf_clr;
  logic [3:0] rptr_gray_sync;
  logic       mem_we;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  fifo_wr_ctrl #(.WIDTH(3), .AFULL_THRESH(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .ovf_clr        (ovf_clr),
    .rptr_gray_sync (rptr_gray_sync),
    .mem_we         (mem_we),
    .waddr          (waddr),
    .wptr_gray      (wptr_gray),
    .full           (full),
    .almost_full    (almost_full),
    .wr_level       (wr_level),
    .overflow       (overflow)
  );

  typedef struct {
    logic       mem_we;
    logic [2:0] waddr;
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic [3:0] level;
    logic       ovf;
  } exp_t;

  exp_t expQ[$];

  int nVec  = 0;
  int nFail = 0;

  // Model state: total writes and reads as plain counts, plus the flags the
  // DUT showed after the previous edge.
  int   wCount = 0;
  int   rCount = 0;
  logic mFull  = 1'b0;
  logic mOvf   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] toGray(input int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic oc, input logic r, input int rc);
    exp_t e;
    int   lvl;
    @(posedge clk);
    #2;
    if (r) rc = 0;
    rCount         = rc;
    wr_en          = w;
    ovf_clr        = oc;
    rst            = r;
    rptr_gray_sync = toGray(rc);
    e.mem_we = w && !mFull && !r;
    e.waddr  = wCount[2:0];
    if (r) begin
      wCount = 0;
      mFull  = 1'b0;
      mOvf   = 1'b0;
      e.gray = 4'd0; e.full = 1'b0; e.afull = 1'b0; e.level = 4'd0; e.ovf = 1'b0;
    end else begin
      if (w && mFull) mOvf = 1'b1;
      else if (oc)    mOvf = 1'b0;
      if (e.mem_we) wCount++;
      lvl     = wCount - rCount;
      mFull   = (lvl == 8);
      e.gray  = toGray(wCount);
      e.full  = mFull;
      e.afull = (lvl >= 6);
      e.level = lvl[3:0];
      e.ovf   = mOvf;
    end
    expQ.push_back(e);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("mem_we", int'(mem_we), int'(e.mem_we));
        checkOutput("waddr", int'(waddr), int'(e.waddr));
        @(posedge clk);
        #1;
        checkOutput("wptr_gray", int'(wptr_gray), int'(e.gray));
        checkOutput("full", int'(full), int'(e.full));
        checkOutput("almost_full", int'(almost_full), int'(e.afull));
        checkOutput("wr_level", int'(wr_level), int'(e.level));
        checkOutput("overflow", int'(overflow), int'(e.ovf));
      end
    end
  end

  initial begin
    int rc;
    rst            = 1'b1;
    wr_en          = 1'b0;
    ovf_clr        = 1'b0;
    rptr_gray_sync = 4'd0;

    // Reset held with writes requested, then fill from empty.
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 0);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 0);
    // Writes while full, then clear attempts with and without a write.
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    // Reader releases one slot, then one write refills it.
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    // Reader jumps to 8; continuous writes wrap wbin through 15 -> 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 8);
    // Reset in the middle of a fill.
    applyStimulus(1'b0, 1'b0, 1'b1, 0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);

    // Randomised traffic with a legal reader that never passes the writer.
    for (int i = 0; i < 2000; i++) begin
      rc = rCount;
      if ($urandom_range(0, 2) == 0 && wCount > rCount) begin
        rc = rCount + int'($urandom_range(0, (wCount - rCount > 3) ? 3 : (wCount - rCount)));
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 199) == 0, rc);
    end

    repeat (3) @(posedge clk);
    #3;
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("[TB] == %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
